menu_overlay_reader: RTL and testbench

//  Read-side engine of the 2 KB menu dual-port RAM. It owns RAM port B as a read-only master.
//  For each video line it walks the 32x28 character map, looks up each code in the 8x8 font,
//  and fills a double-buffered 32-byte line buffer. A 1-cycle pixel lookup then serves the

---
 rtl/menu_overlay_reader.sv | 162 ++++++++++++++++
 tb/tb_menu_overlay_reader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/menu_overlay_reader.sv
// Read-side engine of the menu RAM: fetches one 32-character line of glyph bytes per video line
// into a double-buffered line store and serves single-pixel overlay lookups to the mixer.
module menu_overlay_reader #(
    parameter logic [10:0] FONT_BASE   = 11'h400,
    parameter int          TEXT_ROWS   = 28,
    parameter int          RAM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        line_start,
    input  logic [7:0]  line_y,
    input  logic [7:0]  pix_x,
    output logic        pix_on,
    output logic        fetch_busy,
    output logic        underrun,
    output logic        ram_ce,
    output logic        ram_oce,
    output logic [10:0] ram_adr,
    input  logic [7:0]  ram_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHAR_RD,
        S_CHAR_WT,
        S_GLYPH_RD,
        S_GLYPH_WT,
        S_CLEAR
    } state_t;

    localparam int         BLANK_Y = TEXT_ROWS * 8;
    localparam logic [1:0] WLAST   = 2'(RAM_LATENCY - 1);

    state_t      state_q, state_d;
    logic [4:0]  col_q, col_d;
    logic [1:0]  wcnt_q, wcnt_d;
    logic [7:0]  code_q, code_d;
    logic [7:0]  y_q, y_d;
    logic        sel_q, sel_d;
    logic        underrun_q, underrun_d;
    logic        pix_on_q;
    logic        buf_we;
    logic [7:0]  buf_wdata;
    logic [7:0]  buf_q [2][32];
    logic        wait_done;
    logic        start_blank;

    assign wait_done   = (wcnt_q == WLAST);
    assign start_blank = (int'(line_y) >= BLANK_Y);
    assign fetch_busy  = (state_q != S_IDLE);
    assign underrun    = underrun_q;
    assign pix_on      = pix_on_q;
    assign ram_oce     = 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            wcnt_q     <= '0;
            code_q     <= '0;
            y_q        <= '0;
            sel_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            wcnt_q     <= wcnt_d;
            code_q     <= code_d;
            y_q        <= y_d;
            sel_q      <= sel_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        wcnt_d     = wcnt_q;
        code_d     = code_q;
        y_d        = y_q;
        sel_d      = sel_q;
        underrun_d = underrun_q;
        buf_we     = 1'b0;
        buf_wdata  = 8'h00;
        ram_ce     = 1'b0;
        ram_adr    = 11'h000;

        case (state_q)
            S_CHAR_RD: begin
                ram_ce  = 1'b1;
                ram_adr = {1'b0, y_q[7:3], col_q};
                wcnt_d  = '0;
                state_d = S_CHAR_WT;
            end
            S_CHAR_WT: begin
                if (wait_done) begin
                    code_d  = ram_dout;
                    state_d = S_GLYPH_RD;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            S_GLYPH_RD: begin
                ram_ce  = 1'b1;
                ram_adr = FONT_BASE + {1'b0, code_q[6:0], 3'b000} + {8'b0, y_q[2:0]};
                wcnt_d  = '0;
                state_d = S_GLYPH_WT;
            end
            S_GLYPH_WT: begin
                if (wait_done) begin
                    // Bit 7 of the character code selects inverse video.
                    buf_we    = 1'b1;
                    buf_wdata = code_q[7] ? ~ram_dout : ram_dout;
                    col_d     = col_q + 5'd1;
                    state_d   = (col_q == 5'd31) ? S_IDLE : S_CHAR_RD;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            S_CLEAR: begin
                buf_we  = 1'b1;
                col_d   = col_q + 5'd1;
                state_d = (col_q == 5'd31) ? S_IDLE : S_CLEAR;
            end
            default: state_d = S_IDLE;
        endcase

        // A new line always restarts at column 0; only a completed fetch may be displayed.
        if (line_start) begin
            if (state_q == S_IDLE) begin
                sel_d = ~sel_q;
            end else begin
                underrun_d = 1'b1;
            end
            y_d     = line_y;
            col_d   = '0;
            wcnt_d  = '0;
            state_d = start_blank ? S_CLEAR : S_CHAR_RD;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < 32; c++) begin
                    buf_q[b][c] <= 8'h00;
                end
            end
        end else if (buf_we) begin
            buf_q[~sel_q][col_q] <= buf_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_on_q <= 1'b0;
        end else begin
            pix_on_q <= buf_q[sel_q][pix_x[7:3]][pix_x[2:0]];
        end
    end

endmodule

// File: tb/tb_menu_overlay_reader.sv
// Bench for menu_overlay_reader: latency-1 and latency-2 instances share stimulus and are
// compared every cycle against a line-at-a-time reference model of the overlay fetch.
module tb_menu_overlay_reader;

    logic        clk = 1'b0;
    logic        resetn;
    logic        line_start;
    logic [7:0]  line_y;
    logic [7:0]  pix_x;
    logic [1:0]  pix_on_v, fb_v, ur_v, ce_v, oce_v;
    logic [10:0] adr_v  [2];
    logic [7:0]  dout_v [2];
    logic [7:0]  st1;
    logic [7:0]  mem [2048];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    menu_overlay_reader #(.FONT_BASE(11'h400), .TEXT_ROWS(28), .RAM_LATENCY(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .line_start(line_start), .line_y(line_y), .pix_x(pix_x),
        .pix_on(pix_on_v[0]), .fetch_busy(fb_v[0]), .underrun(ur_v[0]), .ram_ce(ce_v[0]),
        .ram_oce(oce_v[0]), .ram_adr(adr_v[0]), .ram_dout(dout_v[0])
    );

    menu_overlay_reader #(.FONT_BASE(11'h400), .TEXT_ROWS(28), .RAM_LATENCY(2)) u_dut2 (
        .clk(clk), .resetn(resetn), .line_start(line_start), .line_y(line_y), .pix_x(pix_x),
        .pix_on(pix_on_v[1]), .fetch_busy(fb_v[1]), .underrun(ur_v[1]), .ram_ce(ce_v[1]),
        .ram_oce(oce_v[1]), .ram_adr(adr_v[1]), .ram_dout(dout_v[1])
    );

    // Port B RAM models: one registered stage, or registered read plus output register.
    always @(posedge clk) begin
        if (ce_v[0]) dout_v[0] <= mem[adr_v[0]];
        if (ce_v[1]) st1 <= mem[adr_v[1]];
        dout_v[1] <= st1;
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    // Reference model: whole lines are computed at once from the memory image.
    logic [7:0]  disp_m [2][32];
    logic [7:0]  back_m [2][32];
    int          busy_m [2];
    bit          ur_m   [2];
    bit          exp_pix[2];
    bit          prev_busy[2];
    int unsigned adrq0[$];
    int unsigned adrq1[$];
    logic [7:0]  nl [32];
    int unsigned na [64];
    int          LEN [2] = '{128, 192};

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < 32; c++) begin
                    disp_m[i][c] = 8'h00;
                    back_m[i][c] = 8'h00;
                end
                busy_m[i]  = 0;
                ur_m[i]    = 1'b0;
                exp_pix[i] = 1'b0;
            end
            adrq0.delete();
            adrq1.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                exp_pix[i] = disp_m[i][int'(pix_x) / 8][int'(pix_x) % 8];
            end
            if (line_start) begin
                bit blank;
                logic [7:0] code, g;
                blank = (int'(line_y) >= 224);
                for (int c = 0; c < 32; c++) begin
                    na[2*c] = (int'(line_y) / 8) * 32 + c;
                    code = mem[na[2*c]];
                    na[2*c+1] = 1024 + (int'(code) % 128) * 8 + int'(line_y) % 8;
                    g = mem[na[2*c+1]];
                    nl[c] = blank ? 8'h00 : ((code >= 8'd128) ? ~g : g);
                end
                for (int i = 0; i < 2; i++) begin
                    if (busy_m[i] > 0) ur_m[i] = 1'b1;
                    else for (int c = 0; c < 32; c++) disp_m[i][c] = back_m[i][c];
                    for (int c = 0; c < 32; c++) back_m[i][c] = nl[c];
                    busy_m[i] = blank ? 32 : LEN[i];
                end
                adrq0.delete();
                adrq1.delete();
                if (!blank) begin
                    for (int k = 0; k < 64; k++) begin
                        adrq0.push_back(na[k]);
                        adrq1.push_back(na[k]);
                    end
                end
            end else begin
                for (int i = 0; i < 2; i++) if (busy_m[i] > 0) busy_m[i]--;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("pix_on", i, 32'(pix_on_v[i]), 32'(exp_pix[i]));
            chk("fetch_busy", i, 32'(fb_v[i]), 32'(busy_m[i] > 0));
            chk("underrun", i, 32'(ur_v[i]), 32'(ur_m[i]));
            if (ce_v[i]) begin
                if (i == 0 && adrq0.size() > 0) chk("ram_adr", i, 32'(adr_v[i]), adrq0.pop_front());
                else if (i == 1 && adrq1.size() > 0) chk("ram_adr", i, 32'(adr_v[i]), adrq1.pop_front());
                else chk("ram_ce_unexpected", i, 32'(ce_v[i]), 32'd0);
            end
            if (prev_busy[i] && busy_m[i] == 0)
                chk("reads_left_at_end", i, (i == 0) ? adrq0.size() : adrq1.size(), 0);
            prev_busy[i] = (busy_m[i] > 0);
        end
    end

    typedef struct {
        logic [7:0] y;
        int         col;
        logic [7:0] exp;
    } vec_t;

    vec_t tab[6];
    logic [7:0] glyph_a[8];

    task automatic pulse(input logic [7:0] y);
        @(posedge clk);
        #1 line_start = 1'b1;
        line_y = y;
        @(posedge clk);
        #1 line_start = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            if (fb_v == 2'b00) done = 1'b1;
        end
        if (!done) chk("wait_idle_timeout", 0, 32'(fb_v), 32'd0);
    endtask

    task automatic check_byte(input string nm, input int col, input logic [7:0] exp);
        for (int p = 0; p < 8; p++) begin
            @(posedge clk);
            #1 pix_x = 8'(col * 8 + p);
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 2; i++) chk(nm, i, 32'(pix_on_v[i]), 32'(exp[p]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        line_start = 1'b0;
        line_y = 8'd0;
        pix_x = 8'd0;
        for (int a = 0; a < 2048; a++) mem[a] = 8'($urandom);
        glyph_a = '{8'h0C, 8'h1E, 8'h33, 8'h33, 8'h3F, 8'h33, 8'h33, 8'h00};
        for (int r = 0; r < 8; r++) mem[12'h608 + r] = glyph_a[r];
        mem[11'h000] = 8'h41;
        mem[11'h021] = 8'hC1;

        tab[0] = '{8'd1,   0, 8'h1E};
        tab[1] = '{8'd2,   0, 8'h33};
        tab[2] = '{8'd8,   1, 8'hF3};
        tab[3] = '{8'd230, 0, 8'h00};
        tab[4] = '{8'd14,  1, 8'hCC};
        tab[5] = '{8'd4,   0, 8'h3F};

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_pix_on", i, 32'(pix_on_v[i]), 32'd0);
            chk("reset_fetch_busy", i, 32'(fb_v[i]), 32'd0);
            chk("reset_underrun", i, 32'(ur_v[i]), 32'd0);
            chk("reset_ram_ce", i, 32'(ce_v[i]), 32'd0);
            chk("reset_ram_adr", i, 32'(adr_v[i]), 32'd0);
            chk("ram_oce", i, 32'(oce_v[i]), 32'd1);
        end
        @(posedge clk);
        #1 resetn = 1'b1;

        // Directed lines: fetch, swap into view, then sweep one character cell.
        for (int k = 0; k < 6; k++) begin
            pulse(tab[k].y);
            wait_idle();
            pulse(8'd255);
            check_byte("table_pix", tab[k].col, tab[k].exp);
            wait_idle();
        end

        // Underrun: a second line_start 40 cycles into a fetch.
        pulse(8'd1);
        wait_idle();
        pulse(8'd8);
        repeat (40) @(posedge clk);
        for (int i = 0; i < 2; i++) chk("underrun_before", i, 32'(ur_v[i]), 32'd0);
        #1 line_start = 1'b1;
        line_y = 8'd16;
        @(posedge clk);
        #1 line_start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("underrun_set", i, 32'(ur_v[i]), 32'd1);
            chk("restart_ce", i, 32'(ce_v[i]), 32'd1);
            chk("restart_adr", i, 32'(adr_v[i]), 32'h040);
        end
        check_byte("underrun_keeps_display", 0, 8'h1E);
        wait_idle();
        for (int i = 0; i < 2; i++) chk("underrun_sticky", i, 32'(ur_v[i]), 32'd1);

        // Reset in the middle of a fetch.
        pulse(8'd1);
        repeat (40) @(posedge clk);
        #2 resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("midreset_busy", i, 32'(fb_v[i]), 32'd0);
            chk("midreset_ce", i, 32'(ce_v[i]), 32'd0);
            chk("midreset_underrun", i, 32'(ur_v[i]), 32'd0);
        end
        @(posedge clk);
        #1 resetn = 1'b1;
        for (int x = 0; x < 256; x++) begin
            @(posedge clk);
            #1 pix_x = 8'(x);
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 2; i++) chk("post_reset_blank", i, 32'(pix_on_v[i]), 32'd0);
        end

        // Random lines, gaps and pixel positions against the model.
        for (int n = 0; n < 30; n++) begin
            int gap;
            logic [7:0] y;
            y   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(224, 255)) : 8'($urandom_range(0, 223));
            gap = $urandom_range(10, 260);
            pulse(y);
            repeat (gap) begin
                @(posedge clk);
                #1 pix_x = 8'($urandom);
            end
        end
        wait_idle();
        repeat (300) begin
            @(posedge clk);
            #1 pix_x = 8'($urandom);
        end
        @(negedge clk);
        chk("final_queue0", 0, adrq0.size(), 0);
        chk("final_queue1", 1, adrq1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
